// File: rtl/regfile_pkg.sv
// Shared regfile widths and types for the write-port arbiter and its bench.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // Wide enough for the largest supported requester count (8).
    localparam int ARB_IDX_W = 3;
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wreq_t;

endpackage

// File: rtl/regfile_wport_arb_rr_arbiter.sv
// Round-robin priority search: first valid bit at or above ptr, wrapping.
// Purely combinational so it can be reused for a read-port arbiter.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid,
    input  logic [IdxW-1:0] ptr,
    input  logic            hold,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        if (!hold) begin
            // Walk from lowest priority to highest; the last hit (nearest ptr) wins.
            for (int k = N - 1; k >= 0; k--) begin
                cand = (int'(ptr) + k) % N;
                if (valid[cand]) begin
                    grant       = '0;
                    grant[cand] = 1'b1;
                    idx         = IdxW'(cand);
                    any         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arb.sv
// Shares the single regfile write port among NumReq writeback sources, round-robin.
// Define REGFILE_WPORT_SCOREBOARD_EN to add the pending-write busy scoreboard.
module regfile_wport_arb
    import regfile_pkg::*;
#(
    parameter int NumReq     = 3,
    parameter int RegAddrBus = REG_ADDR_W,
    parameter int RegBus     = REG_DATA_W,
    parameter int RegNum     = REG_NUM
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NumReq-1:0]            req_valid,
    output logic [NumReq-1:0]            req_ready,
    input  logic [NumReq*RegAddrBus-1:0] req_addr,
    input  logic [NumReq*RegBus-1:0]     req_data,
    input  logic                         wport_hold,
    output logic                         wen,
    output logic [RegAddrBus-1:0]        waddr,
    output logic [RegBus-1:0]            wdata,
    output logic [$clog2(NumReq)-1:0]    grant_id
`ifdef REGFILE_WPORT_SCOREBOARD_EN
    ,
    input  logic                         rsv_valid,
    input  logic [RegAddrBus-1:0]        rsv_addr,
    input  logic [RegAddrBus-1:0]        busy_raddr1,
    input  logic [RegAddrBus-1:0]        busy_raddr2,
    output logic                         busy1,
    output logic                         busy2
`endif
);

    localparam int IdxW = $clog2(NumReq);

    logic [IdxW-1:0]       rr_ptr;
    logic [IdxW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic [RegAddrBus-1:0] addr_arr [NumReq];
    logic [RegBus-1:0]     data_arr [NumReq];
    logic [RegAddrBus-1:0] sel_addr;
    logic [RegBus-1:0]     sel_data;

    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*RegAddrBus +: RegAddrBus];
        assign data_arr[i] = req_data[i*RegBus +: RegBus];
    end

    // Reset blocks grants so nothing is accepted while the port is being cleared.
    rr_arbiter #(.N(NumReq)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .hold  (wport_hold | rst),
        .grant (req_ready),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_addr = addr_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wen      <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if (gnt_any) begin
            // r0 requests still consume the grant but never reach the regfile.
            wen      <= (sel_addr != RegAddrBus'(REG_ZERO));
            waddr    <= sel_addr;
            wdata    <= sel_data;
            grant_id <= gnt_idx;
            rr_ptr   <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
            wen <= 1'b0;
        end
    end

`ifdef REGFILE_WPORT_SCOREBOARD_EN
    logic [RegNum-1:0] busy;

    always_ff @(posedge clk) begin
        // NOTE: busy is a flop vector, not RAM, and must clear on reset or stale reservations stall issue.
        if (rst) begin
            busy <= '0;
        end else begin
            if (wen) busy[waddr] <= 1'b0;
            // Placed after the clear so a same-address reservation wins.
            if (rsv_valid && rsv_addr != '0) busy[rsv_addr] <= 1'b1;
        end
    end

    assign busy1 = (busy_raddr1 != '0) && busy[busy_raddr1];
    assign busy2 = (busy_raddr2 != '0) && busy[busy_raddr2];
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench: directed literal checks plus random traffic against a behavioural model.
module tb_regfile_wport_arb;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = REG_ADDR_W;
    localparam int DW = REG_DATA_W;
    localparam int IW = $clog2(N);

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*AW-1:0]    req_addr;
    logic [N*DW-1:0]    req_data;
    logic               wport_hold;
    logic               wen;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;
    logic [IW-1:0]      grant_id;
    wreq_t              reqs [N];
`ifdef REGFILE_WPORT_SCOREBOARD_EN
    logic               rsv_valid;
    logic [AW-1:0]      rsv_addr;
    logic [AW-1:0]      busy_raddr1;
    logic [AW-1:0]      busy_raddr2;
    logic               busy1;
    logic               busy2;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Behavioural model state
    int            m_ptr;
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_gid;
    bit            m_busy [REG_NUM];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_addr[i*AW +: AW] = reqs[i].addr;
        assign req_data[i*DW +: DW] = reqs[i].data;
    end

    regfile_wport_arb #(
        .NumReq     (N),
        .RegAddrBus (AW),
        .RegBus     (DW),
        .RegNum     (REG_NUM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .wport_hold (wport_hold),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .grant_id   (grant_id)
`ifdef REGFILE_WPORT_SCOREBOARD_EN
        ,
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .busy_raddr1 (busy_raddr1),
        .busy_raddr2 (busy_raddr2),
        .busy1       (busy1),
        .busy2       (busy2)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Winner under the round-robin rule, or -1 when nothing may be granted.
    function automatic int model_winner();
        if (rst || wport_hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        w = model_winner();
        return (w < 0) ? '0 : N'(1 << w);
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0;
            for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
        end else begin
`ifdef REGFILE_WPORT_SCOREBOARD_EN
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
`endif
            w = model_winner();
            if (w >= 0) begin
                m_waddr = reqs[w].addr;
                m_wdata = reqs[w].data;
                m_gid   = w;
                m_wen   = (reqs[w].addr != 0);
                m_ptr   = (w + 1) % N;
            end else begin
                m_wen = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", req_ready, model_ready());
            check("wen", wen, m_wen);
            check("waddr", waddr, m_waddr);
            check("wdata", wdata, m_wdata);
            check("grant_id", grant_id, m_gid);
`ifdef REGFILE_WPORT_SCOREBOARD_EN
            check("busy1", busy1, (busy_raddr1 != 0) && m_busy[busy_raddr1]);
            check("busy2", busy2, (busy_raddr2 != 0) && m_busy[busy_raddr2]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        for (int i = 0; i < N; i++) reqs[i] = '0;
    endtask

    initial begin
        rst = 1'b1;
        wport_hold = 1'b0;
        clear_reqs();
`ifdef REGFILE_WPORT_SCOREBOARD_EN
        rsv_valid = 1'b0; rsv_addr = '0; busy_raddr1 = '0; busy_raddr2 = '0;
`endif

        // Reset then idle
        repeat (2) begin
            tick();
            check("rst_wen", wen, 0);
            check("rst_waddr", waddr, 0);
            check("rst_wdata", wdata, 0);
            check("rst_ready", req_ready, 0);
        end
        chk_en = 1'b1;
        rst = 1'b0;

        // Round-robin fairness: all valid, order 0,1,2,0,1,2
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            reqs[i].addr = AW'(i + 1);
            reqs[i].data = $urandom;
        end
        for (int k = 0; k < 6; k++) begin
            #1 check("fair_ready", req_ready, 64'(1 << (k % 3)));
            tick();
            check("fair_wen", wen, 1);
            check("fair_gid", grant_id, k % 3);
        end
        clear_reqs();

        // Single request from requester 1
        reqs[1].addr = 5; reqs[1].data = 32'hDEADBEEF; req_valid = 3'b010;
        #1 check("single_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        check("single_wen", wen, 1);
        check("single_waddr", waddr, 5);
        check("single_wdata", wdata, 32'hDEADBEEF);
        check("single_gid", grant_id, 1);

        // r0 write: accepted, no wen
        reqs[0].addr = 0; reqs[0].data = 32'h1234; req_valid = 3'b001;
        #1 check("r0_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("r0_wen", wen, 0);
        check("r0_gid", grant_id, 0);

        // Hold blocks grants; released hold grants requester 2
        wport_hold = 1'b1; reqs[2].addr = 12; reqs[2].data = 32'hCAFE0012; req_valid = 3'b100;
        #1 check("hold_ready", req_ready, 0);
        tick();
        check("hold_wen", wen, 0);
        tick();
        wport_hold = 1'b0;
        #1 check("unhold_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        check("unhold_wen", wen, 1);
        check("unhold_gid", grant_id, 2);
        check("unhold_waddr", waddr, 12);

        // Reset mid-operation
        reqs[0].addr = 7; reqs[0].data = 32'h77; req_valid = 3'b001;
        #1 check("mid_ready", req_ready, 3'b001);
        tick();
        check("mid_wen", wen, 1);
        rst = 1'b1;
        #1 check("mid_rst_ready", req_ready, 0);
        tick();
        check("mid_rst_wen", wen, 0);
        rst = 1'b0;
        reqs[1].addr = 4; req_valid = 3'b011;
        #1 check("mid_ptr0_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("mid_ptr0_gid", grant_id, 0);

`ifdef REGFILE_WPORT_SCOREBOARD_EN
        // Reserve r9, then commit a write to r9
        busy_raddr1 = 9; rsv_valid = 1'b1; rsv_addr = 9;
        tick();
        rsv_valid = 1'b0;
        check("sb_set", busy1, 1);
        clear_reqs();
        reqs[0].addr = 9; req_valid = 3'b001;
        tick();
        req_valid = '0;
        check("sb_pending", busy1, 1);
        tick();
        check("sb_clear", busy1, 0);
        // Same-cycle reserve and commit of r9: reserve wins
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        rsv_valid = 1'b1; rsv_addr = 9;
        tick();
        rsv_valid = 1'b0;
        check("sb_set_wins", busy1, 1);
`endif

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 49) == 0);
            wport_hold = ($urandom_range(0, 4) == 0);
            req_valid  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                reqs[i].addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                reqs[i].data = $urandom;
            end
`ifdef REGFILE_WPORT_SCOREBOARD_EN
            rsv_valid   = $urandom_range(0, 1) == 1;
            rsv_addr    = AW'($urandom);
            busy_raddr1 = AW'($urandom);
            busy_raddr2 = ($urandom_range(0, 1) == 1) ? waddr : AW'($urandom);
`endif
            tick();
        end

        rst = 1'b0;
        wport_hold = 1'b0;
        clear_reqs();
        repeat (2) tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arb.md
Name: regfile_wport_arb

Overview:
- Round-robin arbiter that shares the single regfile write port among NumReq writeback requesters (main WB stage, multi-cycle MUL/DIV, late load return).
- Each requester uses a valid/ready handshake. The winner is registered and drives wen/waddr/wdata into regfile one cycle after acceptance.
- Sits between the writeback sources and regfile. It optionally tracks pending-write reservations for hazard detection.

Parameters:
- NumReq, 3, number of write requesters (2..8)
- RegAddrBus, 5, register address width
- RegBus, 32, register data width
- RegNum, 32, number of architectural registers

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NumReq  per-requester write request
- req_ready  out  NumReq  per-requester grant; combinational, one-hot or zero
- req_addr  in  NumReq*RegAddrBus  packed destination addresses, requester i at slice i
- req_data  in  NumReq*RegBus  packed write data
- wport_hold  in  1  blocks all grants this cycle
- wen  out  1  regfile write enable
- waddr  out  RegAddrBus  regfile write address
- wdata  out  RegBus  regfile write data
- grant_id  out  $clog2(NumReq)  index of the requester whose write is on wen/waddr/wdata
- (macro only) rsv_valid  in  1, rsv_addr  in  RegAddrBus, busy_raddr1/busy_raddr2  in  RegAddrBus, busy1/busy2  out  1

Behaviour:
- Single clock; reset is synchronous and active-high: clk, rst.
- Reset values: wen=0, waddr=0, wdata=0, grant_id=0, rr_ptr=0, scoreboard all clear. req_ready=0 while rst=1.
- Arbitration is combinational and evaluated every cycle:
  - If wport_hold=0, search req_valid starting at rr_ptr upward, wrapping modulo NumReq.
  - The first set bit g gets req_ready[g]=1; all other ready bits are 0.
  - If no request is valid, or wport_hold=1, req_ready is all 0.
- Acceptance occurs when req_valid[g] & req_ready[g]. On the next edge:
  - waddr<=req_addr[g], wdata<=req_data[g], grant_id<=g.
  - wen<=(req_addr[g]!=0).
  - rr_ptr<=(g+1) mod NumReq, wrapping from NumReq-1 to 0.
- No acceptance in a cycle: on the next edge wen<=0; waddr, wdata, grant_id and rr_ptr hold.
- Latency: exactly 1 cycle from acceptance to wen. Throughput is 1 write per cycle, with no bubble between back-to-back grants.
- Address 0: the request is accepted and consumes a grant, but wen stays 0. The regfile never sees an r0 write.
- Requesters must hold valid/addr/data stable until ready. Dropping valid without ready is legal and loses nothing.
- rr_ptr advances only on acceptance, never on hold or an idle cycle.
- Reset mid-operation: an accepted-but-uncommitted write is discarded, and wen=0 in the cycle after reset.

Optional Feature:
- Macro REGFILE_WPORT_SCOREBOARD_EN.
- With the macro defined:
  - A RegNum-bit busy vector is kept.
  - rsv_valid with rsv_addr!=0 sets busy[rsv_addr] at the edge.
  - A commit (wen=1) clears busy[waddr] at the edge.
  - If a set and a clear hit the same address in the same cycle, set wins.
  - busy1=busy[busy_raddr1] and busy2=busy[busy_raddr2], both combinational; an r0 query always returns 0.
- Without the macro: the scoreboard ports and storage are absent; arbitration is unchanged.

Decomposition:
- Package regfile_pkg holds:
  - constants REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, REG_ZERO='0;
  - typedef wreq_t struct {addr, data};
  - typedef arb_idx_t.
- Sub-module rr_arbiter: parameterised round-robin priority search (valid vector, ptr, hold -> one-hot grant, index). It is reusable for a future read-port arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all valid=0 -> wen=0, waddr=0, wdata=0, req_ready=0 for all cycles.
- Single request: req 1 writes addr 5 data 0xDEADBEEF -> ready[1]=1 the same cycle; next cycle wen=1, waddr=5, wdata=0xDEADBEEF, grant_id=1.
- Round-robin fairness: all 3 requesters held valid with addrs 1/2/3 for 6 cycles -> grant order 0,1,2,0,1,2; wen high 6 consecutive cycles.
- r0 and hold:
  - req 0 writes addr 0 -> accepted, next cycle wen=0.
  - wport_hold=1 with req 2 valid -> ready all 0, wen=0, rr_ptr unchanged; hold released -> req 2 granted.
- Reset mid-write: accept req 0 addr 7, assert rst on the next edge -> wen stays 0, rr_ptr=0.
- Scoreboard (macro on): rsv addr 9 -> busy1(9)=1; a write to 9 commits -> busy1=0 the next cycle. A same-cycle rsv 9 plus commit 9 -> busy stays 1.
